// File: rtl/fft_input_buffer.sv
// rtl/fft_input_buffer.sv - collects 16 serial samples into a parallel frame for the FFT butterflies
module fft_input_buffer #(
   parameter int FCNT_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [15:0]       in_data,
   output logic              out_valid,
   output logic [15:0]       x0,
   output logic [15:0]       x1,
   output logic [15:0]       x2,
   output logic [15:0]       x3,
   output logic [15:0]       x4,
   output logic [15:0]       x5,
   output logic [15:0]       x6,
   output logic [15:0]       x7,
   output logic [15:0]       x8,
   output logic [15:0]       x9,
   output logic [15:0]       x10,
   output logic [15:0]       x11,
   output logic [15:0]       x12,
   output logic [15:0]       x13,
   output logic [15:0]       x14,
   output logic [15:0]       x15,
   output logic [3:0]        fill,
   output logic [FCNT_W-1:0] frame_cnt
);

   logic [15:0]       cap_q [15];
   logic [15:0]       cap_d [15];
   logic [15:0]       x_q [16];
   logic [15:0]       x_d [16];
   logic [3:0]        wr_idx_q;
   logic [3:0]        wr_idx_d;
   logic              out_valid_q;
   logic              out_valid_d;
   logic [FCNT_W-1:0] frame_cnt_q;
   logic [FCNT_W-1:0] frame_cnt_d;

   // The 16th sample bypasses the capture buffer and lands directly in x15,
   // so the next frame can start in cap[0] on the very next edge.
   always_comb begin
      cap_d       = cap_q;
      x_d         = x_q;
      wr_idx_d    = wr_idx_q;
      out_valid_d = 1'b0;
      frame_cnt_d = frame_cnt_q;
      if (in_valid) begin
         if (wr_idx_q == 4'd15) begin
            for (int i = 0; i < 15; i++) begin
               x_d[i] = cap_q[i];
            end
            x_d[15]     = in_data;
            wr_idx_d    = 4'd0;
            out_valid_d = 1'b1;
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
         end else begin
            cap_d[wr_idx_q] = in_data;
            wr_idx_d        = wr_idx_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) begin
            cap_q[i] <= 16'd0;
         end
         for (int i = 0; i < 16; i++) begin
            x_q[i] <= 16'd0;
         end
         wr_idx_q    <= 4'd0;
         out_valid_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         cap_q       <= cap_d;
         x_q         <= x_d;
         wr_idx_q    <= wr_idx_d;
         out_valid_q <= out_valid_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign fill      = wr_idx_q;
   assign frame_cnt = frame_cnt_q;
   assign x0        = x_q[0];
   assign x1        = x_q[1];
   assign x2        = x_q[2];
   assign x3        = x_q[3];
   assign x4        = x_q[4];
   assign x5        = x_q[5];
   assign x6        = x_q[6];
   assign x7        = x_q[7];
   assign x8        = x_q[8];
   assign x9        = x_q[9];
   assign x10       = x_q[10];
   assign x11       = x_q[11];
   assign x12       = x_q[12];
   assign x13       = x_q[13];
   assign x14       = x_q[14];
   assign x15       = x_q[15];

endmodule

// File: tb/tb_fft_input_buffer.sv
// tb/tb_fft_input_buffer.sv - directed and model-checked bench for fft_input_buffer
module tb_fft_input_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'd0;
   logic        out_valid;
   logic [15:0] x [16];
   logic [3:0]  fill;
   logic [5:0]  frame_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fft_input_buffer #(.FCNT_W(6)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid),
      .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
      .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
      .x8(x[8]), .x9(x[9]), .x10(x[10]), .x11(x[11]),
      .x12(x[12]), .x13(x[13]), .x14(x[14]), .x15(x[15]),
      .fill(fill), .frame_cnt(frame_cnt)
   );

   // Drive one cycle and return #1 after the edge that consumed it.
   task automatic step(input logic v, input logic [15:0] d);
      in_valid = v;
      in_data  = v ? d : 16'hxxxx;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hdead;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 16'h1111 * 16'(i + 1));
      rst = 1'b1;
      step(1'b1, 16'h7777);
      step(1'b1, 16'h7778);
      rst = 1'b0;
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (fill !== 4'd0) begin n_err++; $display("FAIL reset_fill: got %0d expected 0", fill); end
      n_vec++; if (frame_cnt !== 6'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
      for (int k = 0; k < 16; k++) begin
         n_vec++; if (x[k] !== 16'd0) begin n_err++; $display("FAIL reset_x%0d: got %h expected 0000", k, x[k]); end
      end
   endtask

   task automatic test_basic();
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 16'(i));
         n_vec++; if (out_valid !== (i == 16)) begin n_err++; $display("FAIL basic_out_valid s%0d: got %b expected %b", i, out_valid, i == 16); end
      end
      n_vec++; if (x[0] !== 16'd1) begin n_err++; $display("FAIL basic_x0: got %h expected 0001", x[0]); end
      n_vec++; if (x[7] !== 16'd8) begin n_err++; $display("FAIL basic_x7: got %h expected 0008", x[7]); end
      n_vec++; if (x[15] !== 16'd16) begin n_err++; $display("FAIL basic_x15: got %h expected 0010", x[15]); end
      n_vec++; if (fill !== 4'd0) begin n_err++; $display("FAIL basic_fill: got %0d expected 0", fill); end
      n_vec++; if (frame_cnt !== 6'd1) begin n_err++; $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt); end
      step(1'b0, 16'd0);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse_len: got %b expected 0", out_valid); end
   endtask

   task automatic test_gaps();
      int pulses;
      pulses = 0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         int gap;
         gap = $urandom_range(0, 5);
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 16'd0);
            if (out_valid) pulses++;
            n_vec++; if (fill !== 4'(i)) begin n_err++; $display("FAIL gaps_fill_idle s%0d: got %0d expected %0d", i, fill, i); end
         end
         step(1'b1, 16'h0010 + 16'(i));
         if (out_valid) pulses++;
         n_vec++; if (fill !== 4'((i + 1) % 16)) begin n_err++; $display("FAIL gaps_fill s%0d: got %0d expected %0d", i, fill, (i + 1) % 16); end
      end
      step(1'b0, 16'd0);
      if (out_valid) pulses++;
      n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL gaps_pulses: got %0d expected 1", pulses); end
      n_vec++; if (x[0] !== 16'h0010) begin n_err++; $display("FAIL gaps_x0: got %h expected 0010", x[0]); end
      n_vec++; if (x[15] !== 16'h001f) begin n_err++; $display("FAIL gaps_x15: got %h expected 001f", x[15]); end
   endtask

   task automatic test_back_to_back();
      int first_pulse;
      first_pulse = -1;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 16'd100 + 16'(i));
         n_vec++; if (out_valid !== (i == 15 || i == 31)) begin n_err++; $display("FAIL b2b_out_valid s%0d: got %b expected %b", i, out_valid, i == 15 || i == 31); end
         if (out_valid && first_pulse < 0) first_pulse = i;
         if (i >= 15 && i <= 30) begin
            n_vec++; if (x[0] !== 16'd100 || x[15] !== 16'd115) begin n_err++; $display("FAIL b2b_hold s%0d: got x0=%0d x15=%0d expected 100 115", i, x[0], x[15]); end
         end
         if (i == 16) begin
            n_vec++; if (fill !== 4'd1) begin n_err++; $display("FAIL b2b_fill_restart: got %0d expected 1", fill); end
         end
         if (i == 31) begin
            n_vec++; if (i - first_pulse !== 16) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 16", i - first_pulse); end
            n_vec++; if (x[0] !== 16'd116) begin n_err++; $display("FAIL b2b_x0_f2: got %0d expected 116", x[0]); end
            n_vec++; if (x[15] !== 16'd131) begin n_err++; $display("FAIL b2b_x15_f2: got %0d expected 131", x[15]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 16'h0aa0 + 16'(i));
      rst = 1'b1;
      step(1'b1, 16'h1234);
      rst = 1'b0;
      n_vec++; if (fill !== 4'd0) begin n_err++; $display("FAIL rmid_fill: got %0d expected 0", fill); end
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 16'h8000 + 16'(i));
         n_vec++; if (out_valid !== (i == 15)) begin n_err++; $display("FAIL rmid_out_valid s%0d: got %b expected %b", i, out_valid, i == 15); end
      end
      n_vec++; if (x[0] !== 16'h8000) begin n_err++; $display("FAIL rmid_x0: got %h expected 8000", x[0]); end
      n_vec++; if (x[7] !== 16'h8007) begin n_err++; $display("FAIL rmid_x7: got %h expected 8007", x[7]); end
      n_vec++; if (x[15] !== 16'h800f) begin n_err++; $display("FAIL rmid_x15: got %h expected 800f", x[15]); end
   endtask

   task automatic test_wrap();
      int pulses;
      pulses = 0;
      do_reset();
      for (int f = 1; f <= 64; f++) begin
         for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'(f * 16 + i));
            if (out_valid) pulses++;
         end
         if (f == 63) begin
            n_vec++; if (frame_cnt !== 6'd63) begin n_err++; $display("FAIL wrap_cnt63: got %0d expected 63", frame_cnt); end
         end
      end
      n_vec++; if (frame_cnt !== 6'd0) begin n_err++; $display("FAIL wrap_cnt0: got %0d expected 0", frame_cnt); end
      n_vec++; if (pulses !== 64) begin n_err++; $display("FAIL wrap_pulses: got %0d expected 64", pulses); end
   endtask

   task automatic test_random();
      logic [15:0] m_frame [16];
      logic [15:0] exp_x [16];
      int          m_idx;
      int          m_cnt;
      int          sent;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         m_frame[k] = 16'd0;
         exp_x[k]   = 16'd0;
      end
      m_idx = 0;
      m_cnt = 0;
      sent  = 0;
      while (sent < 2000) begin
         logic        v;
         logic [15:0] d;
         logic        exp_pulse;
         v = ($urandom_range(0, 9) < 7);
         d = 16'($urandom);
         exp_pulse = 1'b0;
         if (v) begin
            sent++;
            m_frame[m_idx] = d;
            if (m_idx == 15) begin
               exp_x     = m_frame;
               exp_pulse = 1'b1;
               m_idx     = 0;
               m_cnt     = (m_cnt + 1) % 64;
            end else begin
               m_idx++;
            end
         end
         step(v, d);
         n_vec++; if (out_valid !== exp_pulse) begin n_err++; $display("FAIL rand_out_valid n%0d: got %b expected %b", sent, out_valid, exp_pulse); end
         n_vec++; if (fill !== 4'(m_idx)) begin n_err++; $display("FAIL rand_fill n%0d: got %0d expected %0d", sent, fill, m_idx); end
         n_vec++; if (frame_cnt !== 6'(m_cnt)) begin n_err++; $display("FAIL rand_frame_cnt n%0d: got %0d expected %0d", sent, frame_cnt, m_cnt); end
         for (int k = 0; k < 16; k++) begin
            n_vec++; if (x[k] !== exp_x[k]) begin n_err++; $display("FAIL rand_x%0d n%0d: got %h expected %h", k, sent, x[k], exp_x[k]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
